// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and helpers for the fp_add_arbiter slice.
// It holds the datapath width, the in-flight tag record, and the index-width helper.
package fp_add_arb_pkg;

    localparam int FP_W      = 32;
    localparam int IDX_MAX_W = 3;   // wide enough for up to 8 requesters

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
    } tag_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester and adder signal bundle for fp_add_arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus the adder.
interface fp_add_arbiter_if #(
    parameter int NREQ = 4
);
    import fp_add_arb_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [FP_W-1:0]      add_a;
    logic [FP_W-1:0]      add_b;
    logic [FP_W-1:0]      add_s;
    logic [NREQ-1:0]      rsp_valid;
    logic [FP_W-1:0]      rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, add_s,
        output req_ready, add_a, add_b, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, add_s,
        input  req_ready, add_a, add_b, rsp_valid, rsp_data
    );

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant with the search starting at r_ptr.
// The pointer advances past the winner on every grant; because a grant implies valid, every grant is a handshake.
module rr_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_valid,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] r_ptr;
    logic          w_hit_hi;
    logic [IW-1:0] w_idx_hi;
    logic [IW-1:0] w_idx_lo;
    logic [IW-1:0] w_idx;
    logic          w_any;
    logic [IW-1:0] w_ptr_nxt;

    // The lowest valid index at or above r_ptr wins; otherwise the lowest valid index overall (wrap).
    always_comb begin
        w_hit_hi = 1'b0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                w_idx_lo = IW'(i);
                if (IW'(i) >= r_ptr) begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = IW'(i);
                end
            end
        end
        w_any = |i_valid;
        w_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = w_any && (w_idx == IW'(i));
        end
    end

    assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
    assign o_idx     = w_idx;
    assign o_any     = w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined FP adder among NREQ requesters, returning each sum to the requester that issued it.
// Optional FP_ADD_ARB_STATS_EN adds the stat_issued and stat_blocked counters.
module fp_add_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_add_arbiter_if.slave  bus
`ifdef FP_ADD_ARB_STATS_EN
    ,
    output logic [FP_W-1:0]  stat_issued,
    output logic [FP_W-1:0]  stat_blocked
`endif
);

    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [FP_W-1:0] w_add_a;
    logic [FP_W-1:0] w_add_b;
    logic [NREQ-1:0] w_rsp_onehot;

    tag_t            r_tag [0:LAT];
    logic [NREQ-1:0] r_rsp_valid;
    logic [FP_W-1:0] r_rsp_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.req_valid),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_add_a = bus.req_a[i*FP_W +: FP_W];
                w_add_b = bus.req_b[i*FP_W +: FP_W];
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.add_a     = w_add_a;
    assign bus.add_b     = w_add_b;

    // Entry 0 plus LAT delay stages: the retiring tag lines up with add_s, which
    // settles LAT cycles after operand capture, so the sum is sampled at edge t+LAT+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_any, idx: IDX_MAX_W'(w_idx)};
            for (int k = 1; k <= LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_rsp_onehot = NREQ'(1) << r_tag[LAT].idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else if (r_tag[LAT].valid) begin
            r_rsp_valid <= w_rsp_onehot;
            r_rsp_data  <= bus.add_s;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

`ifdef FP_ADD_ARB_STATS_EN
    logic [FP_W-1:0] r_stat_issued;
    logic [FP_W-1:0] r_stat_blocked;
    logic            w_blocked;

    assign w_blocked = |(bus.req_valid & ~w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued  <= '0;
            r_stat_blocked <= '0;
        end else begin
            if (w_any) begin
                r_stat_issued <= r_stat_issued + FP_W'(1);
            end
            if (w_blocked) begin
                r_stat_blocked <= r_stat_blocked + FP_W'(1);
            end
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_blocked = r_stat_blocked;
`endif

endmodule
